// File: rtl/freelist_mw.sv
// Multi-lane physical register free list: circular buffer with wrap-bit pointers and head checkpoints.
// Optional FREELIST_PERF_EN adds stall counter and minimum-free watermark outputs.
module freelist_mw #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2,
    parameter int NUM_CKPT  = 4,
    localparam int PHYS_W   = $clog2(PHYS_REGS),
    localparam int PTR_W    = PHYS_W + 1,
    localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ALLOC_W-1:0]        alloc_valid,
    output logic                      alloc_ready,
    output logic [ALLOC_W*PHYS_W-1:0] alloc_pd,
    input  logic [FREE_W-1:0]         free_valid,
    input  logic [FREE_W*PHYS_W-1:0]  free_pd,
    input  logic                      ckpt_take,
    input  logic [CKPT_W-1:0]         ckpt_id,
    input  logic                      restore_valid,
    input  logic [CKPT_W-1:0]         restore_id,
    output logic [PTR_W-1:0]          free_count,
    output logic                      err_overflow
`ifdef FREELIST_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt,
    output logic [PTR_W-1:0]          perf_min_free
`endif
);

    localparam logic [PTR_W-1:0] RESET_TAIL = PTR_W'(PHYS_REGS - ARCH_REGS);
    localparam logic [PTR_W:0]   CAPACITY   = (PTR_W+1)'(PHYS_REGS);

    logic [PHYS_W-1:0] list_q [PHYS_REGS];
    logic [PTR_W-1:0]  ckpt_q [NUM_CKPT];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              ovf_q, ovf_d;

    logic [PTR_W-1:0]  alloc_cnt;
    logic [PTR_W-1:0]  head_alloc;
    logic              do_alloc;

    logic [PTR_W-1:0]                free_acc;
    logic [FREE_W-1:0]               wr_en;
    logic [FREE_W-1:0][PHYS_W-1:0]   wr_idx;
    logic [FREE_W-1:0][PHYS_W-1:0]   wr_pd;
    logic                            drop;

    always_comb begin
        alloc_cnt = '0;
        for (int unsigned i = 0; i < ALLOC_W; i++) begin
            alloc_cnt = alloc_cnt + PTR_W'(alloc_valid[i]);
        end
        free_count  = tail_q - head_q;
        alloc_ready = (free_count >= alloc_cnt) && !restore_valid;
        do_alloc    = alloc_ready && (alloc_valid != '0);
        head_alloc  = do_alloc ? (head_q + alloc_cnt) : head_q;
        alloc_pd    = '0;
        for (int unsigned i = 0; i < ALLOC_W; i++) begin
            alloc_pd[i*PHYS_W +: PHYS_W] = list_q[head_q[PHYS_W-1:0] + PHYS_W'(i)];
        end
    end

    // Frees are compacted in ascending lane order; once the list is full the
    // remaining (higher) lanes are dropped, so the lowest lanes always win.
    always_comb begin
        free_acc = '0;
        wr_en    = '0;
        wr_idx   = '0;
        wr_pd    = '0;
        drop     = 1'b0;
        for (int unsigned i = 0; i < FREE_W; i++) begin
            if (free_valid[i]) begin
                if (({1'b0, free_count} + {1'b0, free_acc}) < CAPACITY) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = tail_q[PHYS_W-1:0] + free_acc[PHYS_W-1:0];
                    wr_pd[i]  = free_pd[i*PHYS_W +: PHYS_W];
                    free_acc  = free_acc + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        tail_d = tail_q + free_acc;
        head_d = restore_valid ? ckpt_q[restore_id] : head_alloc;
        ovf_d  = ovf_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                list_q[i] <= PHYS_W'(ARCH_REGS + i);
            end
            for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                ckpt_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= RESET_TAIL;
            ovf_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < FREE_W; i++) begin
                if (wr_en[i]) begin
                    list_q[wr_idx[i]] <= wr_pd[i];
                end
            end
            if (ckpt_take && !restore_valid) begin
                ckpt_q[ckpt_id] <= head_alloc;
            end
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

    assign err_overflow = ovf_q;

`ifdef FREELIST_PERF_EN
    logic [31:0]      stall_q, stall_d;
    logic [PTR_W-1:0] min_q, min_d;
    logic [PTR_W-1:0] count_next;

    always_comb begin
        stall_d = stall_q;
        if ((alloc_valid != '0) && !alloc_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        count_next = tail_d - head_d;
        min_d      = (count_next < min_q) ? count_next : min_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            min_q   <= RESET_TAIL;
        end else begin
            stall_q <= stall_d;
            min_q   <= min_d;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_min_free  = min_q;
`endif

endmodule

// File: tb/tb_freelist_mw.sv
// Bench for freelist_mw: vector table plus hand sequences for stall, wrap, overflow and reset.
module tb_freelist_mw;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_valid;
    logic        alloc_ready;
    logic [11:0] alloc_pd;
    logic [1:0]  free_valid;
    logic [11:0] free_pd;
    logic        ckpt_take;
    logic [1:0]  ckpt_id;
    logic        restore_valid;
    logic [1:0]  restore_id;
    logic [6:0]  free_count;
    logic        err_overflow;

    always #5 clk = ~clk;

    freelist_mw #(
        .PHYS_REGS(64),
        .ARCH_REGS(32),
        .ALLOC_W  (2),
        .FREE_W   (2),
        .NUM_CKPT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_pd     (alloc_pd),
        .free_valid   (free_valid),
        .free_pd      (free_pd),
        .ckpt_take    (ckpt_take),
        .ckpt_id      (ckpt_id),
        .restore_valid(restore_valid),
        .restore_id   (restore_id),
        .free_count   (free_count),
        .err_overflow (err_overflow)
    );

    typedef struct {
        string name;
        int av, fv, f0, f1, ck, ckid, rv, rid;
        int rdy, pd0, pd1, cnt;
    } vec_t;

    typedef struct {
        string name;
        int rdy, pd0, pd1, cnt, ovf;
    } exp_t;

    vec_t tbl[17];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(string n, int av, int fv, int f0, int f1, int ck, int ckid,
                                int rv, int rid, int rdy, int pd0, int pd1, int cnt);
        vec_t v;
        v.name = n; v.av = av; v.fv = fv; v.f0 = f0; v.f1 = f1; v.ck = ck; v.ckid = ckid;
        v.rv = rv; v.rid = rid; v.rdy = rdy; v.pd0 = pd0; v.pd1 = pd1; v.cnt = cnt;
        return v;
    endfunction

    task automatic cmp(input string name, input string field, input int act, input int exp);
        if (exp >= 0) begin
            n_cmp++;
            if (act != exp) begin
                n_err++;
                $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
            end
        end
    endtask

    // Pops the oldest expectation and compares it against the current outputs.
    task automatic check_sb();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            cmp(e.name, "alloc_ready", int'(alloc_ready), e.rdy);
            cmp(e.name, "pd0", int'(alloc_pd[5:0]), e.pd0);
            cmp(e.name, "pd1", int'(alloc_pd[11:6]), e.pd1);
            cmp(e.name, "free_count", int'(free_count), e.cnt);
            cmp(e.name, "err_overflow", int'(err_overflow), e.ovf);
        end
    endtask

    task automatic expect_now(input string n, input int rdy, input int pd0, input int pd1,
                              input int cnt, input int ovf);
        exp_t e;
        e.name = n; e.rdy = rdy; e.pd0 = pd0; e.pd1 = pd1; e.cnt = cnt; e.ovf = ovf;
        sb.push_back(e);
        check_sb();
    endtask

    task automatic drive(input int av, input int fv, input int f0, input int f1, input int ck,
                         input int ckid, input int rv, input int rid);
        @(negedge clk);
        alloc_valid   = 2'(av);
        free_valid    = 2'(fv);
        free_pd       = {6'(f1), 6'(f0)};
        ckpt_take     = 1'(ck);
        ckpt_id       = 2'(ckid);
        restore_valid = 1'(rv);
        restore_id    = 2'(rid);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; alloc_valid = '0; free_valid = '0; free_pd = '0;
        ckpt_take = 1'b0; ckpt_id = '0; restore_valid = 1'b0; restore_id = '0;

        //                name         av fv f0 f1 ck id rv id  rdy pd0 pd1 cnt
        tbl[0]  = mk("reset_state",  0, 0, 0, 0, 0, 0, 0, 0,  1, 32, 33, 32);
        tbl[1]  = mk("alloc2",       3, 0, 0, 0, 0, 0, 0, 0,  1, 32, 33, 32);
        tbl[2]  = mk("after_alloc2", 0, 0, 0, 0, 0, 0, 0, 0,  1, 34, 35, 30);
        tbl[3]  = mk("ckpt1_alloc",  3, 0, 0, 0, 1, 1, 0, 0,  1, 34, 35, 30);
        tbl[4]  = mk("alloc_b",      3, 0, 0, 0, 0, 0, 0, 0,  1, 36, 37, 28);
        tbl[5]  = mk("alloc_c",      3, 0, 0, 0, 0, 0, 0, 0,  1, 38, 39, 26);
        tbl[6]  = mk("alloc_d",      3, 0, 0, 0, 0, 0, 0, 0,  1, 40, 41, 24);
        tbl[7]  = mk("restore1",     3, 1, 40, 0, 0, 0, 1, 1, 0, 42, 43, 22);
        tbl[8]  = mk("after_rest1",  0, 0, 0, 0, 0, 0, 0, 0,  1, 36, 37, 29);
        tbl[9]  = mk("alloc1_free2", 1, 3, 5, 6, 0, 0, 0, 0,  1, 36, 37, 29);
        tbl[10] = mk("free_lane1",   0, 2, 0, 7, 0, 0, 0, 0,  1, 37, 38, 30);
        tbl[11] = mk("after_frees",  0, 0, 0, 0, 0, 0, 0, 0,  1, 37, 38, 31);
        tbl[12] = mk("rest_vs_ckpt", 0, 0, 0, 0, 1, 2, 1, 1,  0, 37, 38, 31);
        tbl[13] = mk("after_rest2",  0, 0, 0, 0, 0, 0, 0, 0,  1, 36, 37, 32);
        tbl[14] = mk("alloc_e",      3, 0, 0, 0, 0, 0, 0, 0,  1, 36, 37, 32);
        tbl[15] = mk("restore2",     0, 0, 0, 0, 0, 0, 1, 2,  0, 38, 39, 30);
        tbl[16] = mk("slot2_zero",   0, 0, 0, 0, 0, 0, 0, 0,  1, 32, 33, 36);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            exp_t e;
            drive(tbl[i].av, tbl[i].fv, tbl[i].f0, tbl[i].f1, tbl[i].ck, tbl[i].ckid,
                  tbl[i].rv, tbl[i].rid);
            e.name = tbl[i].name; e.rdy = tbl[i].rdy; e.pd0 = tbl[i].pd0;
            e.pd1 = tbl[i].pd1; e.cnt = tbl[i].cnt; e.ovf = 0;
            sb.push_back(e);
            check_sb();
        end

        // Exhaust to one free register: all-or-nothing grant, then single-lane grant of p63.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            drive(3, 0, 0, 0, 0, 0, 0, 0);
            expect_now("drain_pair", 1, 32 + 2*k, 33 + 2*k, 32 - 2*k, 0);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_now("drain_single", 1, 62, -1, 2, 0);
        drive(3, 0, 0, 0, 0, 0, 0, 0);
        expect_now("stall_pair", 0, 63, -1, 1, 0);
        drive(3, 0, 0, 0, 0, 0, 0, 0);
        expect_now("stall_hold", 0, 63, -1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_now("grant_p63", 1, 63, -1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_now("empty_stall", 0, -1, -1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("empty_idle", 1, -1, -1, 0, 0);

        // Same-cycle alloc and free: freed registers appear only on the next cycle.
        drive(0, 3, 10, 11, 0, 0, 0, 0);
        expect_now("refill", 1, -1, -1, 0, 0);
        drive(3, 3, 20, 21, 0, 0, 0, 0);
        expect_now("alloc_free_same", 1, 10, 11, 2, 0);
        drive(3, 0, 0, 0, 0, 0, 0, 0);
        expect_now("freed_next", 1, 20, 21, 2, 0);
        idle();
        expect_now("freed_drained", 1, -1, -1, 0, 0);

        // Head wrap: two lanes straddling index 63 and 0.
        do_reset();
        for (int k = 0; k < 16; k++) drive(3, 0, 0, 0, 0, 0, 0, 0);
        idle();
        expect_now("wrap_empty", 1, -1, -1, 0, 0);
        for (int j = 0; j < 16; j++) drive(0, 3, (2*j) ^ 42, (2*j + 1) ^ 42, 0, 0, 0, 0);
        drive(0, 1, 32 ^ 42, 0, 0, 0, 0, 0);
        idle();
        expect_now("wrap_filled", 1, -1, -1, 33, 0);
        for (int k = 0; k < 15; k++) drive(3, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(3, 0, 0, 0, 0, 0, 0, 0);
        expect_now("wrap_lanes", 1, 31 ^ 42, 32 ^ 42, 2, 0);
        idle();
        expect_now("wrap_after", 1, -1, -1, 0, 0);
        drive(0, 1, 9, 0, 0, 0, 0, 0);
        idle();
        expect_now("wrap_head1", 1, 9, -1, 1, 0);

        // Overflow: lane 1 dropped when only one slot remains; flag is sticky.
        do_reset();
        for (int j = 0; j < 15; j++) drive(0, 3, 2*j, 2*j + 1, 0, 0, 0, 0);
        drive(0, 1, 30, 0, 0, 0, 0, 0);
        idle();
        expect_now("ovf_63", 1, -1, -1, 63, 0);
        drive(0, 3, 21, 43, 0, 0, 0, 0);
        idle();
        expect_now("ovf_partial", 1, -1, -1, 64, 1);
        drive(0, 1, 3, 0, 0, 0, 0, 0);
        idle();
        expect_now("ovf_full", 1, -1, -1, 64, 1);
        for (int k = 0; k < 31; k++) drive(3, 0, 0, 0, 0, 0, 0, 0);
        drive(3, 0, 0, 0, 1, 3, 0, 0);
        expect_now("ovf_kept_lane0", 1, 30, 21, 2, 1);
        idle();
        expect_now("ovf_sticky", 1, -1, -1, 0, 1);

        // Reset overrides concurrent activity and clears checkpoints and the sticky flag.
        rst = 1'b1;
        drive(3, 3, 1, 2, 1, 3, 1, 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        expect_now("rst_override", 1, 32, 33, 32, 0);
        drive(3, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 3);
        expect_now("rst_restore", 0, 34, 35, 30, 0);
        idle();
        expect_now("rst_ckpt_zero", 1, 32, 33, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
